// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one UART transmitter among N_REQ byte requesters.
//            Accepts one byte from the round-robin winner over a valid/ready
//            handshake, drives the transmitter's one-cycle Enable strobe and
//            parallel byte, then times the whole frame itself because the
//            transmitter has no busy output.
// Revision : 1.0 - initial release
//
// Parameters
//   N_REQ         number of requesters (2..8)
//   CLKS_PER_BIT  clocks per UART bit, must match the transmitter instance
//   GAP_CYCLES    extra idle clocks inserted between frames
//
// Ports
//   clk        in   system clock, all logic on posedge
//   rst_n      in   asynchronous reset, active-low
//   req_valid  in   [N_REQ]    requester i holds a byte on req_data[8i+7:8i]
//   req_data   in   [8*N_REQ]  packed request bytes
//   req_ready  out  [N_REQ]    one-hot grant, combinational
//   tx_enable  out  registered one-cycle strobe to transmitter Enable
//   tx_data    out  [8]        registered byte to transmitter Tx_Parallel
//   busy       out  high in every state except IDLE
//   grant_id   out  [clog2(N_REQ)] index of the last accepted requester
//
// Build option
//   UART_TX_ARB_FIXED_PRI_EN  when defined, fixed priority (lowest index
//                             wins) replaces round-robin and the rotating
//                             pointer is removed. Default: round-robin.
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int CLKS_PER_BIT = 868,
  parameter int GAP_CYCLES   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx_enable,
  output logic [7:0]               tx_data,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id
);

  localparam int ID_W  = $clog2(N_REQ);
  // Transmitter LOAD cycle + 10 bit-times + 1 cycle to re-enter its IDLE.
  localparam int FRAME = 10 * CLKS_PER_BIT + 2;
  localparam int CNT_W = $clog2(FRAME + GAP_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_RESET  = CNT_W'(FRAME);
  // LAUNCH and the IDLE accept cycle already consume two clocks of the frame.
  localparam logic [CNT_W-1:0] CNT_LAUNCH = CNT_W'(FRAME + GAP_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [ID_W-1:0]  LAST_ID    = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              tx_enable_q;
  logic [7:0]        tx_data_q;
  logic [ID_W-1:0]   grant_id_q;

`ifndef UART_TX_ARB_FIXED_PRI_EN
  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   rr_ptr_d;
`endif

  logic [ID_W-1:0]   win_id;
  logic              win_any;
  logic [ID_W-1:0]   cand;
  logic              accept;
  logic [7:0]        win_byte;

  // --------------------------------------------------------------------------
  // Winner search. The loop runs from the lowest-priority candidate upward so
  // the last hit, i.e. the highest-priority valid requester, is kept.
  // --------------------------------------------------------------------------
  always_comb begin
    win_id  = '0;
    win_any = 1'b0;
    cand    = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
`ifdef UART_TX_ARB_FIXED_PRI_EN
      cand = ID_W'(off);
`else
      // Candidate index wraps around starting at the round-robin pointer.
      cand = ID_W'((int'(rr_ptr_q) + off) % N_REQ);
`endif
      if (req_valid[cand]) begin
        win_any = 1'b1;
        win_id  = cand;
      end
    end
  end

  // Grants are only offered in IDLE; WAIT and LAUNCH keep every ready low.
  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && win_any) begin
      req_ready[win_id] = 1'b1;
    end
  end

  assign accept   = |(req_valid & req_ready);
  assign win_byte = req_data[{win_id, 3'b000} +: 8];

`ifndef UART_TX_ARB_FIXED_PRI_EN
  // The requester just served becomes lowest priority.
  assign rr_ptr_d = (win_id == LAST_ID) ? '0 : win_id + ID_W'(1);
`endif

  // --------------------------------------------------------------------------
  // Control FSM. Reset lands in WAIT with a full frame on the counter: the
  // transmitter is not reset and may still be shifting a byte, so no new
  // grant may start before that frame has had time to finish.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_WAIT;
      cnt_q       <= CNT_RESET;
      tx_enable_q <= 1'b0;
      tx_data_q   <= 8'h00;
      grant_id_q  <= '0;
`ifndef UART_TX_ARB_FIXED_PRI_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            tx_data_q   <= win_byte;
            tx_enable_q <= 1'b1;
            grant_id_q  <= win_id;
`ifndef UART_TX_ARB_FIXED_PRI_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
            state_q     <= S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          tx_enable_q <= 1'b0;
          cnt_q       <= CNT_LAUNCH;
          state_q     <= S_WAIT;
        end

        S_WAIT: begin
          // WAIT ends on the clock where the counter reaches zero, which puts
          // the next accept exactly FRAME+GAP_CYCLES clocks after the last.
          if (cnt_q <= CNT_ONE) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        default: begin
          tx_enable_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_enable = tx_enable_q;
  assign tx_data   = tx_data_q;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter (N_REQ=4,
//            CLKS_PER_BIT=4, GAP_CYCLES=0, so one frame is 42 clocks).
//            The reference model tracks when the next grant is allowed, the
//            round-robin pointer and the last accepted byte; a behavioural
//            transmitter and receiver check the serial loopback.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int CPB   = 4;
  localparam int GAP   = 0;
  localparam int FRAME = 10 * CPB + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        tx_enable;
  logic [7:0]  tx_data;
  logic        busy;
  logic [1:0]  grant_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ       (N),
    .CLKS_PER_BIT(CPB),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .tx_enable(tx_enable),
    .tx_data  (tx_data),
    .busy     (busy),
    .grant_id (grant_id)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  int         edge_n  = 0;   // clock edges driven through cycle()
  int         free_at = 0;   // first edge at which a new accept is allowed
  int         ptr     = 0;   // round-robin start index
  int         exp_gid = 0;
  logic [7:0] exp_data = 8'h00;
  logic       exp_en  = 1'b0;
  int         m_win   = -1;  // model winner of the last cycle, -1 if none
  logic [3:0] last_rdy = '0; // DUT ready seen in the last cycle
  int         obs_gid[$];
  int         obs_edge[$];

  // Behavioural transmitter: start bit, 8 data bits LSB-first, stop bit.
  // Data bits are read live from tx_data, so any instability corrupts them.
  logic ser = 1'b1;
  initial begin
    forever begin
      @(negedge clk);
      if (tx_enable === 1'b1) begin
        ser = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          ser = tx_data[i];
          repeat (CPB) @(negedge clk);
        end
        ser = 1'b1;
        repeat (CPB) @(negedge clk);
      end
    end
  end

  // One clock: drive at the negedge, check ready/busy, step the model on the
  // posedge, check registered outputs at the following negedge.
  task automatic cycle(input logic [3:0] v, input logic [31:0] d);
    logic [3:0] exp_rdy;
    int         win;
    logic       exp_busy;
    req_valid = v;
    req_data  = d;
    #1;
    win = -1;
    if (edge_n + 1 >= free_at) begin
      for (int o = N - 1; o >= 0; o--) begin
`ifdef UART_TX_ARB_FIXED_PRI_EN
        if (v[o]) win = o;
`else
        if (v[(ptr + o) % N]) win = (ptr + o) % N;
`endif
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    exp_busy = (edge_n + 1 < free_at);
    last_rdy = req_ready;
    n_cmp++;
    if (req_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL ready e%0d: got %b want %b", edge_n + 1, req_ready, exp_rdy);
    end
    n_cmp++;
    if (busy !== exp_busy) begin
      n_fail++;
      $display("FAIL busy e%0d: got %b want %b", edge_n + 1, busy, exp_busy);
    end
    @(posedge clk);
    edge_n++;
    m_win = win;
    if (win >= 0) begin
      exp_en   = 1'b1;
      exp_data = d[8*win +: 8];
      exp_gid  = win;
      ptr      = (win + 1) % N;
      free_at  = edge_n + FRAME + GAP;
    end else begin
      exp_en = 1'b0;
    end
    @(negedge clk);
    n_cmp++;
    if (tx_enable !== exp_en) begin
      n_fail++;
      $display("FAIL tx_enable e%0d: got %b want %b", edge_n, tx_enable, exp_en);
    end
    n_cmp++;
    if (tx_data !== exp_data) begin
      n_fail++;
      $display("FAIL tx_data e%0d: got %h want %h", edge_n, tx_data, exp_data);
    end
    n_cmp++;
    if (grant_id !== exp_gid[1:0]) begin
      n_fail++;
      $display("FAIL grant_id e%0d: got %0d want %0d", edge_n, grant_id, exp_gid);
    end
    if (tx_enable === 1'b1) begin
      obs_gid.push_back(int'(grant_id));
      obs_edge.push_back(edge_n);
    end
  endtask

  // Asserts reset at a negedge, checks the reset outputs, releases it.
  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    n_cmp++;
    if (tx_enable !== 1'b0 || busy !== 1'b1 || req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got en=%b busy=%b rdy=%b want 0 1 0000",
               tx_enable, busy, req_ready);
    end
    n_cmp++;
    if (tx_data !== 8'h00 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got data=%h gid=%0d want 00 0", tx_data, grant_id);
    end
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    free_at  = edge_n + FRAME + 1;
    ptr      = 0;
    exp_data = 8'h00;
    exp_gid  = 0;
    exp_en   = 1'b0;
    obs_gid.delete();
    obs_edge.delete();
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 4; c++) cycle(4'b0000, 32'h0);
  endtask

  task automatic test_single();
    int   e0;
    int   first;
    logic sent;
    do_reset();
    e0    = edge_n;
    first = -1;
    sent  = 1'b0;
    for (int c = 0; c < FRAME + 20; c++) begin
      cycle(sent ? 4'b0000 : 4'b0001, 32'h0000_003C);
      if (first < 0 && last_rdy[0] === 1'b1) first = edge_n - 1 - e0;
      if (m_win == 0) sent = 1'b1;
    end
    n_cmp++;
    if (first !== FRAME) begin
      n_fail++;
      $display("FAIL first_ready: got %0d want %0d", first, FRAME);
    end
    n_cmp++;
    if (obs_gid.size() !== 1) begin
      n_fail++;
      $display("FAIL single_pulses: got %0d want 1", obs_gid.size());
    end
  endtask

  task automatic test_round_robin();
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int c = 0; c < 6 * FRAME && obs_gid.size() < 5; c++)
      cycle(4'b1111, 32'hA3A2_A1A0);
    n_cmp++;
    if (obs_gid.size() !== 5) begin
      n_fail++;
      $display("FAIL rr_count: got %0d want 5", obs_gid.size());
    end
    for (int i = 0; i < obs_gid.size() && i < 5; i++) begin
`ifndef UART_TX_ARB_FIXED_PRI_EN
      n_cmp++;
      if (obs_gid[i] !== exp_ord[i]) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got %0d want %0d", i, obs_gid[i], exp_ord[i]);
      end
`endif
      if (i > 0) begin
        n_cmp++;
        if (obs_edge[i] - obs_edge[i-1] !== FRAME + GAP) begin
          n_fail++;
          $display("FAIL rr_spacing[%0d]: got %0d want %0d", i,
                   obs_edge[i] - obs_edge[i-1], FRAME + GAP);
        end
      end
    end
  endtask

  task automatic test_loopback();
    logic [7:0] bytes[2] = '{8'h55, 8'hA3};
    do_reset();
    for (int c = 0; c < FRAME; c++) cycle(4'b0000, 32'h0);
    fork
      begin
        for (int b = 0; b < 2; b++) begin
          for (int c = 0; c < 2 * FRAME; c++) begin
            cycle(4'b0100, {8'h00, bytes[b], 16'h0000});
            if (m_win == 2) break;
          end
        end
        for (int c = 0; c < FRAME + 10; c++) cycle(4'b0000, 32'h0);
      end
      begin
        for (int b = 0; b < 2; b++) begin
          logic [9:0] fr;
          int         waited;
          waited = 0;
          while (ser !== 1'b0 && waited < 4 * FRAME) begin
            @(posedge clk);
            waited++;
          end
          n_cmp++;
          if (waited >= 4 * FRAME) begin
            n_fail++;
            $display("FAIL loop_start[%0d]: got no start bit want one", b);
          end else begin
            repeat (CPB / 2) @(posedge clk);
            for (int k = 0; k < 10; k++) begin
              fr[k] = ser;
              if (k < 9) repeat (CPB) @(posedge clk);
            end
            if (fr !== {1'b1, bytes[b], 1'b0}) begin
              n_fail++;
              $display("FAIL loop_frame[%0d]: got %b want %b", b, fr,
                       {1'b1, bytes[b], 1'b0});
            end
          end
        end
      end
    join
  endtask

  task automatic test_reset_mid();
    int quiet;
    do_reset();
    for (int c = 0; c < 2 * FRAME; c++) begin
      cycle(4'b0010, 32'h0000_5A00);
      if (m_win >= 0) break;
    end
    for (int c = 0; c < 10; c++) cycle(4'b0000, 32'h0);
    do_reset();
    quiet = 0;
    for (int c = 0; c < FRAME + 5; c++) begin
      cycle(4'b1111, 32'h1122_3344);
      if (last_rdy === 4'b0000 && quiet == c) quiet++;
    end
    n_cmp++;
    if (quiet !== FRAME) begin
      n_fail++;
      $display("FAIL reset_quiet: got %0d want %0d", quiet, FRAME);
    end
  endtask

  task automatic test_withdraw();
    do_reset();
    for (int c = 0; c < 5; c++) cycle(4'b0000, 32'h0);
    cycle(4'b0010, 32'h0000_7700);
    for (int c = 0; c < FRAME + 5; c++) cycle(4'b0000, 32'h0);
    n_cmp++;
    if (obs_gid.size() !== 0) begin
      n_fail++;
      $display("FAIL withdraw_pulses: got %0d want 0", obs_gid.size());
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL withdraw_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_random();
    logic [3:0]  pend;
    logic [31:0] dat;
    pend = '0;
    dat  = '0;
    do_reset();
    for (int c = 0; c < 900; c++) begin
      for (int r = 0; r < N; r++) begin
        if (pend[r]) begin
          if ($urandom_range(0, 15) == 0) pend[r] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          pend[r]        = 1'b1;
          dat[8*r +: 8]  = 8'($urandom);
        end
      end
      cycle(pend, dat);
      if (m_win >= 0) pend[m_win] = 1'b0;
    end
  endtask

`ifdef UART_TX_ARB_FIXED_PRI_EN
  task automatic test_fixed_pri();
    do_reset();
    for (int c = 0; c < 4 * FRAME && obs_gid.size() < 3; c++)
      cycle(4'b1111, 32'hB3B2_B1B0);
    n_cmp++;
    if (obs_gid.size() !== 3) begin
      n_fail++;
      $display("FAIL fixed_count: got %0d want 3", obs_gid.size());
    end
    for (int i = 0; i < obs_gid.size(); i++) begin
      n_cmp++;
      if (obs_gid[i] !== 0) begin
        n_fail++;
        $display("FAIL fixed_winner[%0d]: got %0d want 0", i, obs_gid[i]);
      end
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_loopback();
    test_reset_mid();
    test_withdraw();
    test_random();
`ifdef UART_TX_ARB_FIXED_PRI_EN
    test_fixed_pri();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
